// File: rtl/jk_pkg.sv
// jk_pkg: JK command encoding and helper functions for the jkff_bank slice.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package jk_pkg;

  // Command encoding is the raw {J,K} pair
  typedef enum logic [1:0] {
    HOLD   = 2'b00,
    RESET  = 2'b01,
    SET    = 2'b10,
    TOGGLE = 2'b11
  } jk_cmd_e;

  // popcount operates on a fixed-width vector; callers zero-extend into it,
  // so a bank may be at most JK_MAX_W bits wide.
  localparam int JK_MAX_W = 64;
  localparam int JK_POP_W = 7;

  function automatic logic jk_next(input jk_cmd_e cmd, input logic q);
    logic r;
    case (cmd)
      HOLD:    r = q;
      RESET:   r = 1'b0;
      SET:     r = 1'b1;
      default: r = ~q;
    endcase
    return r;
  endfunction

  function automatic logic [JK_POP_W-1:0] popcount(input logic [JK_MAX_W-1:0] v);
    logic [JK_POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < JK_MAX_W; i++) begin
      n = n + JK_POP_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/jkff_cell.sv
// jkff_cell: one JK flop with a parallel-load override and a per-edge change flag.
// Latency: the presented command takes effect on the next rising edge of CLK.
// Backpressure: none; a new command is accepted every cycle.
module jkff_cell
  import jk_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [1:0] cmd,
  input  logic       load,
  input  logic       load_data,
  output logic       q,
  output logic       changed
);

  logic q_nxt;

  // Load overrides whatever JK command is presented
  always_comb begin
    q_nxt = load ? load_data : jk_next(jk_cmd_e'(cmd), q);
  end

  // Flop value and its change flag update on the same edge
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q       <= RESET_VAL;
      changed <= 1'b0;
    end else begin
      q       <= q_nxt;
      changed <= q_nxt ^ q;
    end
  end

endmodule

// File: rtl/jkff_bank.sv
// jkff_bank: WIDTH independent JK flops with bank load, change flags and a saturating flip counter.
// Latency: 2 edges with PIPE=1 (registered command), 1 edge with PIPE=0; CLR_CNT always 1 edge.
// Backpressure: none; one command is accepted every cycle at full rate.
module jkff_bank
  import jk_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               PIPE      = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_DATA,
  input  logic             CLR_CNT,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] CHANGED,
  output logic [CNT_W-1:0] TOGGLE_CNT
);

  // Command as seen by the flops (registered or direct)
  logic             en_a;
  logic             load_a;
  logic [WIDTH-1:0] j_a;
  logic [WIDTH-1:0] k_a;
  logic [WIDTH-1:0] ld_a;

  if (PIPE != 0) begin : g_pipe
    logic             en_r;
    logic             load_r;
    logic [WIDTH-1:0] j_r;
    logic [WIDTH-1:0] k_r;
    logic [WIDTH-1:0] ld_r;

    // Command stage; reset leaves an idle command so nothing in flight survives
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        en_r   <= 1'b0;
        load_r <= 1'b0;
        j_r    <= '0;
        k_r    <= '0;
        ld_r   <= '0;
      end else begin
        en_r   <= EN;
        load_r <= LOAD;
        j_r    <= J;
        k_r    <= K;
        ld_r   <= LOAD_DATA;
      end
    end

    assign en_a   = en_r;
    assign load_a = load_r;
    assign j_a    = j_r;
    assign k_a    = k_r;
    assign ld_a   = ld_r;
  end else begin : g_direct
    assign en_a   = EN;
    assign load_a = LOAD;
    assign j_a    = J;
    assign k_a    = K;
    assign ld_a   = LOAD_DATA;
  end

  logic             load_app;
  jk_cmd_e          cmd [WIDTH];
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] flips;

  assign load_app = en_a & load_a;

  // Per-bit applied command; next value is also needed here to count flips
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      cmd[i]   = en_a ? jk_cmd_e'({j_a[i], k_a[i]}) : HOLD;
      q_nxt[i] = load_app ? ld_a[i] : jk_next(cmd[i], Q[i]);
    end
  end

  assign flips = q_nxt ^ Q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jkff_cell #(
      .RESET_VAL (RESET_VAL[i])
    ) u_cell (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .cmd       (cmd[i]),
      .load      (load_app),
      .load_data (ld_a[i]),
      .q         (Q[i]),
      .changed   (CHANGED[i])
    );
  end

  logic [JK_MAX_W-1:0] flips_ext;
  logic [CNT_W:0]      cnt_sum;
  logic [CNT_W-1:0]    cnt_nxt;

  // Add this edge's flips with one spare bit, then clamp at all-ones
  always_comb begin
    flips_ext              = '0;
    flips_ext[WIDTH-1:0]   = flips;
    cnt_sum                = {1'b0, TOGGLE_CNT} + (CNT_W+1)'(popcount(flips_ext));
    cnt_nxt                = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
  end

  // Clear discards the same edge's increment
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      TOGGLE_CNT <= '0;
    end else if (CLR_CNT) begin
      TOGGLE_CNT <= '0;
    end else begin
      TOGGLE_CNT <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_jkff_bank.sv
// tb_jkff_bank: scoreboard bench for two jkff_bank configurations driven from shared stimulus.
// Latency: instance a is PIPE=1 (2 edges), instance b is PIPE=0 (1 edge).
// Backpressure: none; one command per cycle.
module tb_jkff_bank;

  logic       CLK;
  logic       rst_n;
  logic       en;
  logic [7:0] j;
  logic [7:0] k;
  logic       load;
  logic [7:0] load_data;
  logic       clr_cnt;

  logic [7:0] q_a, changed_a, cnt_a;
  logic [7:0] q_b, changed_b;
  logic [3:0] cnt_b;

  jkff_bank #(
    .WIDTH     (8),
    .PIPE      (1),
    .RESET_VAL (8'hA5),
    .CNT_W     (8)
  ) u_dut_a (
    .CLK        (CLK),
    .RST_N      (rst_n),
    .EN         (en),
    .J          (j),
    .K          (k),
    .LOAD       (load),
    .LOAD_DATA  (load_data),
    .CLR_CNT    (clr_cnt),
    .Q          (q_a),
    .CHANGED    (changed_a),
    .TOGGLE_CNT (cnt_a)
  );

  jkff_bank #(
    .WIDTH     (8),
    .PIPE      (0),
    .RESET_VAL (8'h00),
    .CNT_W     (4)
  ) u_dut_b (
    .CLK        (CLK),
    .RST_N      (rst_n),
    .EN         (en),
    .J          (j),
    .K          (k),
    .LOAD       (load),
    .LOAD_DATA  (load_data),
    .CLR_CNT    (clr_cnt),
    .Q          (q_b),
    .CHANGED    (changed_b),
    .TOGGLE_CNT (cnt_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] chg;
  } exp_t;

  exp_t       sb_a[$];
  exp_t       sb_b[$];
  logic [7:0] mq_a, mq_b;
  int         mc_a, mc_b;
  int         n_chk;
  int         n_fail;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_next(input logic [7:0] q, input logic e,
                                            input logic [7:0] jj, input logic [7:0] kk,
                                            input logic ld, input logic [7:0] ldd);
    logic [7:0] r;
    if (!e) return q;
    if (ld) return ldd;
    for (int i = 0; i < 8; i++) begin
      case ({jj[i], kk[i]})
        2'b00:   r[i] = q[i];
        2'b01:   r[i] = 1'b0;
        2'b10:   r[i] = 1'b1;
        default: r[i] = ~q[i];
      endcase
    end
    return r;
  endfunction

  function automatic int sat_add(input int a, input int b, input int m);
    return (a + b > m) ? m : a + b;
  endfunction

  // Model state after reset; the PIPE=1 instance applies an idle command first
  task automatic model_reset();
    sb_a.delete();
    sb_b.delete();
    mq_a = 8'hA5;
    mq_b = 8'h00;
    mc_a = 0;
    mc_b = 0;
    sb_a.push_back({8'hA5, 8'h00});
  endtask

  // Drive one command, predict it, then compare both instances after the edge
  task automatic drive(input logic e, input logic [7:0] jj, input logic [7:0] kk,
                       input logic ld, input logic [7:0] ldd, input logic clr);
    exp_t       ea, eb;
    logic [7:0] nx;
    en = e; j = jj; k = kk; load = ld; load_data = ldd; clr_cnt = clr;
    nx = model_next(mq_a, e, jj, kk, ld, ldd);
    sb_a.push_back({nx, nx ^ mq_a});
    mq_a = nx;
    nx = model_next(mq_b, e, jj, kk, ld, ldd);
    sb_b.push_back({nx, nx ^ mq_b});
    mq_b = nx;
    @(posedge CLK);
    #1;
    if (sb_a.size() > 0) begin
      ea   = sb_a.pop_front();
      mc_a = clr ? 0 : sat_add(mc_a, $countones(ea.chg), 255);
      check("a_q", q_a, ea.q);
      check("a_changed", changed_a, ea.chg);
      check("a_cnt", cnt_a, mc_a);
    end
    if (sb_b.size() > 0) begin
      eb   = sb_b.pop_front();
      mc_b = clr ? 0 : sat_add(mc_b, $countones(eb.chg), 15);
      check("b_q", q_b, eb.q);
      check("b_changed", changed_b, eb.chg);
      check("b_cnt", cnt_b, mc_b);
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0;
    en = 1'b0; j = '0; k = '0; load = 1'b0; load_data = '0; clr_cnt = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_a_q", q_a, 8'hA5);
    check("rst_a_changed", changed_a, 8'h00);
    check("rst_a_cnt", cnt_a, 8'h00);
    check("rst_b_q", q_b, 8'h00);
    check("rst_b_cnt", cnt_b, 4'h0);
    model_reset();
    rst_n = 1'b1;

    // Bring both banks to 0x00 with a cleared counter
    drive(1'b1, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1);
    // Per-bit commands: 7:6 set, 5:4 toggle up from 0, 3:2 reset, 1:0 hold
    drive(1'b1, 8'hF0, 8'h3C, 1'b0, 8'h00, 1'b0);
    check("b_pb_q", q_b, 8'hF0);
    drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    check("a_pb_q", q_a, 8'hF0);
    check("a_pb_changed", changed_a, 8'hF0);
    check("a_pb_cnt", cnt_a, 8'd4);

    // Load beats J/K; PIPE=0 instance sees it on the first edge
    drive(1'b1, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b0);
    drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1);
    drive(1'b1, 8'hFF, 8'hFF, 1'b1, 8'h0F, 1'b0);
    check("b_ld_q", q_b, 8'h0F);
    check("b_ld_changed", changed_b, 8'hF0);
    check("b_ld_cnt", cnt_b, 4'd4);
    drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1);

    // Saturation of the 4-bit counter
    drive(1'b1, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0);
    check("b_sat8", cnt_b, 4'd8);
    drive(1'b1, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0);
    check("b_sat15", cnt_b, 4'd15);
    check("b_tog_changed", changed_b, 8'hFF);
    drive(1'b1, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0);
    check("b_sat_hold", cnt_b, 4'd15);
    drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);

    // Clear collides with a pipelined toggle of bit 0: flip happens, count is lost
    drive(1'b1, 8'h01, 8'h01, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1);
    check("a_clr_cnt", cnt_a, 8'd0);
    check("a_clr_changed", changed_a, 8'h01);

    // Disabled commands are ignored
    for (int n = 0; n < 3; n++) begin
      drive(1'b0, 8'hFF, 8'hFF, 1'b1, 8'h55, 1'b0);
      check("b_dis_changed", changed_b, 8'h00);
      check("a_dis_changed", changed_a, 8'h00);
    end

    // Random mix
    for (int n = 0; n < 40; n++) begin
      drive(($urandom % 4) != 0, 8'($urandom), 8'($urandom), ($urandom % 5) == 0,
            8'($urandom), ($urandom % 7) == 0);
    end

    // Async reset mid-cycle with a command in the stage and another on the inputs
    drive(1'b1, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0);
    en = 1'b1; j = 8'h0F; k = 8'h00; load = 1'b0; clr_cnt = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_a_q", q_a, 8'hA5);
    check("arst_a_changed", changed_a, 8'h00);
    check("arst_a_cnt", cnt_a, 8'h00);
    check("arst_b_q", q_b, 8'h00);
    check("arst_b_changed", changed_b, 8'h00);
    check("arst_b_cnt", cnt_b, 4'h0);
    model_reset();
    @(posedge CLK);
    #1;
    en = 1'b0; j = '0; k = '0;
    rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
      check("post_rst_a_q", q_a, 8'hA5);
      check("post_rst_b_q", q_b, 8'h00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
